// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: MSB-first serial word shifter with ones-run detector and hit counter.
module serial_pattern_gen #(
  parameter int WIDTH   = 24,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             exp_z,
  output logic [7:0]       hit_cnt
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(RUN_LEN + 1);
  typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    bcnt, bcnt_n;
  logic [RW-1:0]    rcnt, rcnt_n, rcnt_inc;
  logic [7:0]       hit_n;
  logic             shift, capture, last, x_n, exp_z_n;
  assign busy = (state == SHIFT);
  always_comb begin
    shift    = (state == SHIFT);
    capture  = load && (state == IDLE || state == LOADED);
    last     = (bcnt == CW'(WIDTH - 1));
    rcnt_inc = (rcnt == RW'(RUN_LEN)) ? rcnt : rcnt + 1'b1;
    state_n  = state;
    case (state)
      IDLE:    state_n = load ? LOADED : IDLE;
      LOADED:  state_n = (start && !load) ? SHIFT : LOADED;
      SHIFT:   state_n = stop ? LOADED : (last && !cont) ? DONE : SHIFT;
      default: state_n = LOADED;
    endcase
    sreg_n  = capture ? load_data : shift ? {sreg[WIDTH-2:0], sreg[WIDTH-1]} : sreg;
    bcnt_n  = (shift && !stop && !last) ? bcnt + 1'b1 : '0;
    x_n     = shift && sreg[WIDTH-1];
    rcnt_n  = x_n ? rcnt_inc : '0;
    exp_z_n = x_n && (rcnt_inc == RW'(RUN_LEN));
    // a fresh load clears the count even if a hit is still pending
    hit_n   = capture ? '0 : (exp_z && hit_cnt != 8'hFF) ? hit_cnt + 8'd1 : hit_cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bcnt    <= '0;
      rcnt    <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
      exp_z   <= 1'b0;
      hit_cnt <= '0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      bcnt    <= bcnt_n;
      rcnt    <= rcnt_n;
      x       <= x_n;
      x_valid <= shift;
      done    <= (state == DONE);
      exp_z   <= exp_z_n;
      hit_cnt <= hit_n;
    end
  end
endmodule
